// File: rtl/pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : pipe_pkg                                                   |
// | Brief   : Shared opcode constants, instruction field positions and   |
// |           decode helpers for the decode/execute pipeline stage.      |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package pipe_pkg;

  // Primary opcodes recognised by the decode logic
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Instruction field bit positions (MSB / LSB)
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;

  // Hard-wired zero register and link register
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  // Logical immediates are zero-extended; everything else sign-extends
  function automatic logic is_zero_ext(input logic [5:0] opcode);
    return (opcode == OP_ANDI) || (opcode == OP_ORI) ||
           (opcode == OP_XORI) || (opcode == OP_LUI);
  endfunction

  // Instructions that read rt as a source operand
  function automatic logic uses_rt(input logic [5:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_SW) ||
           (opcode == OP_BEQ)   || (opcode == OP_BNE);
  endfunction

  // Instructions that never write the register file
  function automatic logic no_writeback(input logic [5:0] opcode);
    return (opcode == OP_SW) || (opcode == OP_BEQ) ||
           (opcode == OP_BNE) || (opcode == OP_J);
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_fwd_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : id_ex_fwd_mux                                              |
// | Brief   : Three-source operand forwarding mux with $0 override.      |
// |           EX/MEM beats MEM/WB, which beats the register file.       |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module id_ex_fwd_mux
  import pipe_pkg::*;
(
  input  logic [4:0]  src_addr,
  input  logic [31:0] rf_data,
  input  logic        exm_wr_en,
  input  logic [4:0]  exm_wr_addr,
  input  logic [31:0] exm_result,
  input  logic        mwb_wr_en,
  input  logic [4:0]  mwb_wr_addr,
  input  logic [31:0] mwb_wr_data,
  output logic [31:0] fwd_data
);

  // Pick the youngest producer of src_addr; $0 always reads as zero
  always_comb begin
    fwd_data = rf_data;
    if (src_addr == REG_ZERO) begin
      fwd_data = 32'd0;
    end else if (exm_wr_en && (exm_wr_addr == src_addr)) begin
      fwd_data = exm_result;
    end else if (mwb_wr_en && (mwb_wr_addr == src_addr)) begin
      fwd_data = mwb_wr_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : id_ex_stage                                                |
// | Brief   : ID/EX pipeline register with decode, operand forwarding,   |
// |           load-use hazard detection and a bubble counter.           |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        elk,
  input  logic        nrst,
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  input  logic [31:0] id_pc,
  input  logic [31:0] rd_dataA,
  input  logic [31:0] rd_dataB,
  input  logic        stall,
  input  logic        flush,
  input  logic        exm_wr_en,
  input  logic [4:0]  exm_wr_addr,
  input  logic [31:0] exm_result,
  input  logic        mwb_wr_en,
  input  logic [4:0]  mwb_wr_addr,
  input  logic [31:0] mwb_wr_data,
  output logic        ex_valid,
  output logic [31:0] ex_opA,
  output logic [31:0] ex_opB,
  output logic [31:0] ex_imm,
  output logic [5:0]  ex_opcode,
  output logic [5:0]  ex_funct,
  output logic [4:0]  ex_shamt,
  output logic [4:0]  ex_rd_addr,
  output logic        ex_wr_en,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic [31:0] ex_pc,
  output logic        hazard_stall,
  output logic [15:0] bubble_cnt
);

  // Decoded fields of the instruction in the decode slot
  logic [5:0]  w_opcode;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_shamt;
  logic [5:0]  w_funct;
  logic [15:0] w_imm16;
  logic [4:0]  w_dest;
  logic [31:0] w_imm_ext;
  logic        w_wr_en;
  logic        w_rt_used;
  logic [31:0] w_fwd_a;
  logic [31:0] w_fwd_b;
  logic        w_hazard;

  // EX-slot pipeline registers
  logic        r_valid;
  logic [31:0] r_opA;
  logic [31:0] r_opB;
  logic [31:0] r_imm;
  logic [5:0]  r_opcode;
  logic [5:0]  r_funct;
  logic [4:0]  r_shamt;
  logic [4:0]  r_rd_addr;
  logic        r_wr_en;
  logic        r_mem_read;
  logic        r_mem_write;
  logic [31:0] r_pc;
  logic [15:0] r_bubble_cnt;

  assign w_opcode = id_instr[OPCODE_MSB:OPCODE_LSB];
  assign w_rs     = id_instr[RS_MSB:RS_LSB];
  assign w_rt     = id_instr[RT_MSB:RT_LSB];
  assign w_rd     = id_instr[RD_MSB:RD_LSB];
  assign w_shamt  = id_instr[SHAMT_MSB:SHAMT_LSB];
  assign w_funct  = id_instr[FUNCT_MSB:FUNCT_LSB];
  assign w_imm16  = id_instr[IMM_MSB:IMM_LSB];

  // Destination register selection, immediate extension and write enable
  always_comb begin
    if (w_opcode == OP_RTYPE) begin
      w_dest = w_rd;
    end else if (w_opcode == OP_JAL) begin
      w_dest = REG_RA;
    end else begin
      w_dest = w_rt;
    end
    w_imm_ext = is_zero_ext(w_opcode) ? {16'h0000, w_imm16}
                                      : {{16{w_imm16[15]}}, w_imm16};
    w_wr_en   = id_valid && (w_dest != REG_ZERO) && !no_writeback(w_opcode);
    w_rt_used = uses_rt(w_opcode);
  end

  id_ex_fwd_mux u_fwd_a (
    .src_addr    (w_rs),
    .rf_data     (rd_dataA),
    .exm_wr_en   (exm_wr_en),
    .exm_wr_addr (exm_wr_addr),
    .exm_result  (exm_result),
    .mwb_wr_en   (mwb_wr_en),
    .mwb_wr_addr (mwb_wr_addr),
    .mwb_wr_data (mwb_wr_data),
    .fwd_data    (w_fwd_a)
  );

  id_ex_fwd_mux u_fwd_b (
    .src_addr    (w_rt),
    .rf_data     (rd_dataB),
    .exm_wr_en   (exm_wr_en),
    .exm_wr_addr (exm_wr_addr),
    .exm_result  (exm_result),
    .mwb_wr_en   (mwb_wr_en),
    .mwb_wr_addr (mwb_wr_addr),
    .mwb_wr_data (mwb_wr_data),
    .fwd_data    (w_fwd_b)
  );

  // Load in EX whose result is needed now: its data only exists one cycle later.
  // r_wr_en already implies a non-zero destination, so rs/rt == $0 never matches.
  always_comb begin
    w_hazard = r_valid && r_mem_read && r_wr_en && id_valid && !stall &&
               ((r_rd_addr == w_rs) || (w_rt_used && (r_rd_addr == w_rt)));
  end

  // EX slot: flush > stall > bubble > normal load
  always_ff @(posedge elk or negedge nrst) begin
    if (!nrst) begin
      r_valid     <= 1'b0;
      r_opA       <= 32'd0;
      r_opB       <= 32'd0;
      r_imm       <= 32'd0;
      r_opcode    <= 6'd0;
      r_funct     <= 6'd0;
      r_shamt     <= 5'd0;
      r_rd_addr   <= 5'd0;
      r_wr_en     <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_pc        <= RESET_PC;
    end else if (flush) begin
      r_valid     <= 1'b0;
      r_opA       <= 32'd0;
      r_opB       <= 32'd0;
      r_imm       <= 32'd0;
      r_opcode    <= 6'd0;
      r_funct     <= 6'd0;
      r_shamt     <= 5'd0;
      r_rd_addr   <= 5'd0;
      r_wr_en     <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_pc        <= RESET_PC;
    end else if (stall) begin
      r_valid     <= r_valid;
    end else if (w_hazard) begin
      // Bubble: the data fields are don't-care, only the side effects are killed
      r_valid     <= 1'b0;
      r_wr_en     <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else begin
      r_valid     <= id_valid;
      r_opA       <= w_fwd_a;
      r_opB       <= w_fwd_b;
      r_imm       <= w_imm_ext;
      r_opcode    <= w_opcode;
      r_funct     <= w_funct;
      r_shamt     <= w_shamt;
      r_rd_addr   <= w_dest;
      r_wr_en     <= w_wr_en;
      r_mem_read  <= id_valid && (w_opcode == OP_LW);
      r_mem_write <= id_valid && (w_opcode == OP_SW);
      r_pc        <= id_pc;
    end
  end

  // Saturating count of bubbles actually inserted (flush overrides the bubble)
  always_ff @(posedge elk or negedge nrst) begin
    if (!nrst) begin
      r_bubble_cnt <= 16'd0;
    end else if (!flush && w_hazard && (r_bubble_cnt != 16'hFFFF)) begin
      r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end
  end

  assign ex_valid     = r_valid;
  assign ex_opA       = r_opA;
  assign ex_opB       = r_opB;
  assign ex_imm       = r_imm;
  assign ex_opcode    = r_opcode;
  assign ex_funct     = r_funct;
  assign ex_shamt     = r_shamt;
  assign ex_rd_addr   = r_rd_addr;
  assign ex_wr_en     = r_wr_en;
  assign ex_mem_read  = r_mem_read;
  assign ex_mem_write = r_mem_write;
  assign ex_pc        = r_pc;
  assign hazard_stall = w_hazard;
  assign bubble_cnt   = r_bubble_cnt;

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
# id_ex_stage

Decode/execute pipeline stage sitting directly downstream of the 32×32 register file. It captures the read operands (`rd_dataA`, `rd_dataB`) together with the decoded instruction fields, and resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages. It also detects load-use hazards and inserts one bubble per hazard. Its outputs feed the ALU / execute stage.

## Interface
- `RESET_PC`, default 32'h0000_0000: value of `ex_pc` after reset and flush.
- `elk`  in  1  pipeline clock; all state updates on its rising edge.
- `nrst`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  decode slot holds a real instruction.
- `id_instr`  in  32  instruction word; rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0].
- `id_pc`  in  32  PC of `id_instr`.
- `rd_dataA` / `rd_dataB`  in  32  register file read data for rs / rt.
- `stall`  in  1  downstream hold request.
- `flush`  in  1  squash request (taken branch/jump).
- `exm_wr_en`, `exm_wr_addr[4:0]`, `exm_result[31:0]`  in  EX/MEM forwarding source.
- `mwb_wr_en`, `mwb_wr_addr[4:0]`, `mwb_wr_data[31:0]`  in  MEM/WB forwarding source; same values drive the register file write port.
- `ex_valid`  out  1  EX slot valid.
- `ex_opA`, `ex_opB`  out  32  forwarded operands.
- `ex_imm`  out  32  extended immediate.
- `ex_opcode`, `ex_funct`  out  6 each; `ex_shamt`  out  5.
- `ex_rd_addr`  out  5  destination register.
- `ex_wr_en`, `ex_mem_read`, `ex_mem_write`  out  1 each.
- `ex_pc`  out  32.
- `hazard_stall`  out  1  combinational; upstream (PC, IF/ID) must hold while high.
- `bubble_cnt`  out  16  saturating count of inserted load-use bubbles.

## Operation
- Destination register:
  - opcode 0 → rd.
  - opcode 0x03 (jal) → 31.
  - otherwise → rt.
- `ex_wr_en` = 0 when the destination is 0, or when opcode ∈ {0x2B sw, 0x04 beq, 0x05 bne, 0x02 j}.
- Immediate: zero-extended for opcodes 0x0C, 0x0D, 0x0E, 0x0F; sign-extended otherwise.
- `ex_mem_read` = (opcode==0x23); `ex_mem_write` = (opcode==0x2B).
- rt is used when opcode ∈ {0x00, 0x2B, 0x04, 0x05}.
- Forwarding, evaluated per operand at capture time, source register s:
  - s==0 → 0.
  - `exm_wr_en` && `exm_wr_addr`==s → `exm_result`.
  - `mwb_wr_en` && `mwb_wr_addr`==s → `mwb_wr_data`.
  - otherwise → register file data.
  - EX/MEM has priority over MEM/WB.
- `hazard_stall` = `ex_valid` && `ex_mem_read` && `ex_wr_en` && `id_valid` && !`stall` && (`ex_rd_addr`==rs || (rt used && `ex_rd_addr`==rt)).
- Per-edge priority, highest first:
  1. `flush`: `ex_valid`←0; all other outputs ← reset values.
  2. `stall`: hold every register.
  3. `hazard_stall`: `ex_valid`←0 (bubble); increment `bubble_cnt`, saturating at 16'hFFFF.
  4. Otherwise: load from the decode slot; `ex_valid`←`id_valid`.
- A bubble or invalid slot forces `ex_wr_en`, `ex_mem_read` and `ex_mem_write` to 0.

## Timing
- Latency: one `elk` cycle from decode inputs to `ex_*` outputs.
- `nrst` low clears immediately, independent of `elk`:
  - all outputs → 0, except `ex_pc` → `RESET_PC`.
  - `bubble_cnt` → 0; `hazard_stall` → 0 (because `ex_valid`=0).
- Reset mid-operation drops the in-flight instruction; there is no replay.
- `rd_dataA`/`rd_dataB` must be settled at the rising edge of `elk`. A register file write in the same cycle is covered by MEM/WB forwarding.
- A load-use hazard costs exactly one bubble. On the next cycle the load sits in EX/MEM and the dependent instruction forwards from `exm_result`.
- `stall` and `hazard_stall` together: `stall` wins, no bubble is inserted, and the counter does not increment.
- `flush` together with `stall`: the flush is still taken.

## Structure
- Package `pipe_pkg`:
  - opcode constants (OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW).
  - instruction field bit positions.
  - register-zero index.
- Sub-module `id_ex_fwd_mux`: the 3-source forwarding mux with zero-register override. It is instantiated twice, once for A and once for B.
- Everything else (decode, hazard logic, pipeline registers, counter) lives in `id_ex_stage`.

## Test plan
- Reset and decode:
  - pulse `nrst` low mid-cycle → all outputs 0 immediately, `ex_pc`=`RESET_PC`.
  - then load `add $3,$1,$2` (32'h00221820) with `rd_dataA`=5, `rd_dataB`=7 → next edge `ex_opA`=5, `ex_opB`=7, `ex_rd_addr`=3, `ex_wr_en`=1.
- Forwarding priority: rs=1, `exm_wr_addr`=1 with `exm_result`=0xAA, `mwb_wr_addr`=1 with `mwb_wr_data`=0xBB → `ex_opA`=0xAA. With `exm_wr_en`=0 → `ex_opA`=0xBB. With rs=0 → `ex_opA`=0.
- Load-use: `lw $4,0($1)` followed by `add $5,$4,$4` →
  - `hazard_stall`=1 for one cycle, `ex_valid`=0 bubble, `bubble_cnt`=1.
  - the add issues on the following edge.
- Stall vs. hazard: hold `stall`=1 during the load-use condition → outputs unchanged, `hazard_stall`=0, `bubble_cnt` unchanged.
- Flush: assert `flush` and `stall` with a valid sw in the decode slot → `ex_valid`=0, `ex_mem_write`=0.
- Immediate extension:
  - `ori` imm 0x8000 → `ex_imm`=0x00008000.
  - `addi` imm 0x8000 → 0xFFFF8000.
  - destination $0 → `ex_wr_en`=0.
